// File: rtl/data_memory_if.sv
// data_memory_if: MEM-stage load/store bus between the datapath and data_memory
//   Address   byte address from the ALU
//   WriteData store data
//   MemWrite  write enable, active-high
//   MemRead   read enable, active-high
//   ReadData  registered load data
interface data_memory_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  modport master (output Address, WriteData, MemWrite, MemRead, input ReadData);
  modport slave  (input Address, WriteData, MemWrite, MemRead, output ReadData);
endinterface

// File: rtl/data_memory.sv
// data_memory: word-organised single-port data memory, synchronous write, registered read
//   Clk    system clock, rising edge
//   Rst_n  asynchronous active-low reset, clears ReadData only
//   bus    data_memory_if.slave (Address, WriteData, MemWrite, MemRead, ReadData)
//   DATAMEM_WRITE_FIRST_EN: when defined, a same-edge read+write returns WriteData;
//   otherwise the word's previous contents are returned
module data_memory #(
  parameter int ADDR_WIDTH = 10
) (
  input logic         Clk,
  input logic         Rst_n,
  data_memory_if.slave bus
);
  logic [31:0] mem [2**ADDR_WIDTH] = '{default: '0};
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] rd_next;
  assign idx = bus.Address[ADDR_WIDTH+1:2];
  always_comb begin
`ifdef DATAMEM_WRITE_FIRST_EN
    rd_next = bus.MemWrite ? bus.WriteData : mem[idx];
`else
    rd_next = mem[idx];
`endif
  end
  // Array has no reset; gating on Rst_n drops any write on an edge during reset
  always_ff @(posedge Clk) begin
    if (Rst_n && bus.MemWrite) mem[idx] <= bus.WriteData;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) bus.ReadData <= '0;
    else if (bus.MemRead) bus.ReadData <= rd_next;
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory
module tb_data_memory;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  data_memory_if bus();
  data_memory dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] exp);
    n_cmp++;
    assert (bus.ReadData === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.ReadData, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a;
    bus.WriteData = d;
    bus.MemWrite = 1'b1;
    bus.MemRead = 1'b0;
    tick();
    bus.MemWrite = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    bus.Address = a;
    bus.MemRead = 1'b1;
    bus.MemWrite = 1'b0;
    tick();
    bus.MemRead = 1'b0;
  endtask
  initial begin
    bus.Address = '0;
    bus.WriteData = '0;
    bus.MemWrite = 1'b0;
    bus.MemRead = 1'b1;
    tick();
    tick();
    check("reset_hold", 32'h0);
    Rst_n = 1'b1;
    bus.MemRead = 1'b0;
    rd(32'h0);
    check("read_unwritten_0", 32'h0);
    wr(32'h0, 32'hDEADBEEF);
    check("write_no_read_hold", 32'h0);
    rd(32'h0);
    check("rw_addr0", 32'hDEADBEEF);
    wr(32'h4, 32'hBEEFCAFE);
    rd(32'h4);
    check("rw_addr4", 32'hBEEFCAFE);
    rd(32'h0);
    check("addr0_kept", 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) wr(32'h8 + 32'(4 * i), 32'hAABBCCDD + 32'(i));
    for (int i = 0; i < 5; i++) begin
      rd(32'h8 + 32'(4 * i));
      check($sformatf("sweep_%0d", i), 32'hAABBCCDD + 32'(i));
    end
    rd(32'h4);
    for (int i = 0; i < 3; i++) begin
      bus.Address = 32'h10 + 32'(4 * i);
      tick();
      check($sformatf("hold_%0d", i), 32'hBEEFCAFE);
    end
    rd(32'h8);
    check("pre_alias", 32'hAABBCCDD);
    rd(32'h5);
    check("misaligned_5", 32'hBEEFCAFE);
    rd(32'h1000);
    check("wrap_1000", 32'hDEADBEEF);
    wr(32'h1008, 32'h5A5A5A5A);
    rd(32'h8);
    check("wrap_write_1008", 32'h5A5A5A5A);
    wr(32'h20, 32'h11111111);
    bus.Address = 32'h20;
    bus.WriteData = 32'h22222222;
    bus.MemWrite = 1'b1;
    bus.MemRead = 1'b1;
    tick();
    bus.MemWrite = 1'b0;
    bus.MemRead = 1'b0;
`ifdef DATAMEM_WRITE_FIRST_EN
    check("simul_rw", 32'h22222222);
`else
    check("simul_rw", 32'h11111111);
`endif
    rd(32'h20);
    check("simul_after", 32'h22222222);
    wr(32'h24, 32'h33333333);
    rd(32'h24);
    check("pre_reset_24", 32'h33333333);
    Rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0);
    bus.Address = 32'h24;
    bus.WriteData = 32'h44444444;
    bus.MemWrite = 1'b1;
    tick();
    check("reset_during_edge", 32'h0);
    bus.MemWrite = 1'b0;
    Rst_n = 1'b1;
    rd(32'h24);
    check("write_blocked_24", 32'h33333333);
    rd(32'h0);
    check("mem_survives_reset", 32'hDEADBEEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
